snake_tail_sprite_pipe: RTL
===========================

Name: snake_tail_sprite_pipe

Overview:
- Pixel-pipeline stage directly upstream and downstream of the 16x16 red-tail sprite ROM.
- Takes VGA pixel coordinates and syncs from the timing generator, plus the tail cell position and direction from game logic.
- Generates the rotated ROM address, colour-keys the returned texel over the background, and emits RGB with the syncs re-aligned.
- Tail position updates are frame-synchronous through a valid/ready shadow register.

Parameters:
- GRID_W, 40, grid width in cells; cell_x >= GRID_W is never drawn.
- GRID_H, 30, grid height in cells; cell_y >= GRID_H is never drawn.
- KEY0, 24'h1a1a1c, first transparent texel colour.
- KEY1, 24'h181b1d, second transparent texel colour.

Ports:
- i_clk  in  1  pixel clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_px_x  in  10  current pixel column.
- i_px_y  in  10  current pixel row.
- i_de  in  1  active-video enable.
- i_hsync  in  1  horizontal sync, passed through.
- i_vsync  in  1  vertical sync, active-high; its rising edge marks the frame boundary.
- i_bg_rgb  in  24  background pixel, aligned with i_px_x/i_px_y.
- i_tail_cell_x  in  6  new tail cell column.
- i_tail_cell_y  in  5  new tail cell row.
- i_tail_dir  in  2  new tail direction: 0 = up (stored), 1 = right, 2 = down, 3 = left.
- i_tail_valid  in  1  new tail position offered.
- o_tail_ready  out  1  pending slot empty.
- o_rom_addr  out  8  sprite ROM address, registered.
- i_rom_data  in  24  sprite ROM data (ROM is combinational on o_rom_addr).
- o_rgb  out  24  output pixel.
- o_de  out  1  delayed i_de.
- o_hsync  out  1  delayed i_hsync.
- o_vsync  out  1  delayed i_vsync.

Behaviour:
- Reset (async assert, sync release):
  - o_rom_addr=0, o_rgb=0, o_de=0, o_hsync=0, o_vsync=0.
  - pending and active tail cleared, with valid flags =0.
  - o_tail_ready=1 from the first clock after release.
  - Reset mid-frame aborts the pipeline; no tail is drawn until the next commit.
- Tail handshake:
  - Accept when i_tail_valid & o_tail_ready: load the pending register, set pending_valid, drop o_tail_ready.
  - Commit on the cycle after a detected i_vsync rising edge (vs_d1 & ~vs_d2) while pending_valid: active <= pending, active_valid=1, pending_valid=0, o_tail_ready=1.
  - An accept in the same cycle as the edge detection does not commit until the next frame edge.
  - i_tail_valid while ready is low is ignored (held by the producer).
- Stage 1 (registered):
  - u = i_px_x[3:0], v = i_px_y[3:0].
  - hit = i_de & active_valid & (i_px_x[9:4] == active_x) & (i_px_y[9:4] == active_y) & (active_x < GRID_W) & (active_y < GRID_H).
  - o_rom_addr is updated every cycle regardless of hit:
    - dir0: {v,u}
    - dir1: {15-u, v}
    - dir2: {15-v, 15-u}
    - dir3: {u, 15-v}
  - hit, de, hsync, vsync and bg_rgb are delayed with it.
- Stage 2 (registered):
  - If ~de_d1: o_rgb = 0.
  - Else if hit_d1 and i_rom_data is neither KEY0 nor KEY1: o_rgb = i_rom_data.
  - Else: o_rgb = bg_d1.
  - o_de, o_hsync and o_vsync are the 2-cycle delayed inputs.
- Latency: exactly 2 clocks from i_px/i_de/syncs/i_bg_rgb to o_rgb/o_de/o_*sync; throughput 1 pixel per clock, no stalls.
- All 4-bit subtractions are modulo 16 (15-x = ~x).
- Tail at the grid edge (cell 39, 29) draws normally.
- Out-of-range cells draw nothing and the output equals the background.

Decomposition:
- Package snake_gfx_pkg:
  - rgb_t (logic [23:0]).
  - dir_t enum {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT}.
  - CELL_LOG2=4.
  - default key colours.
- One sub-module, tail_addr_rotate: combinational (u, v, dir) -> 8-bit address. It is reused later for the head sprite.
- The sprite ROM is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then no handshake; sweep a frame with i_bg_rgb=24'h00ff00 -> o_rgb=00ff00 on every de pixel, o_rgb=0 when de=0; o_tail_ready=1.
- Offer cell (2,1) dir0, then a vsync pulse; at pixel (32,16) next frame -> o_rom_addr=0x00; at pixel (36,16) -> o_rom_addr=0x04 and, with ROM data f42834, o_rgb=f42834 two cycles after the pixel.
- dir1/dir2/dir3 at pixel offset u=3, v=0 -> o_rom_addr = 0xC0 / 0xFC / 0x3F respectively.
- Inside the hit cell with ROM data 1a1a1c or 181b1d -> o_rgb=i_bg_rgb (delayed 2); with cf212b -> cf212b.
- Offer two positions back-to-back before vsync -> the second waits with ready=0 and is not accepted; after the edge the first is drawn and ready returns to 1; the tail does not move mid-frame.
- Assert i_rst_n low mid-line with the tail drawn -> all outputs are 0 immediately; after release the frame shows background only until a new commit; cell_x=45 committed -> never drawn.

Source files
------------

// File: rtl/snake_gfx_pkg.sv
// rtl/snake_gfx_pkg.sv - shared types and constants for the snake sprite pixel stages
package snake_gfx_pkg;

   typedef logic [23:0] rgb_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   localparam int CELL_LOG2 = 4;

   localparam rgb_t KEY0_DEFAULT = 24'h1a1a1c;
   localparam rgb_t KEY1_DEFAULT = 24'h181b1d;

endpackage

// File: rtl/tail_addr_rotate.sv
// rtl/tail_addr_rotate.sv - maps in-cell texel coords and facing to a 16x16 sprite ROM address
module tail_addr_rotate
   import snake_gfx_pkg::*;
(
   input  logic [3:0] u,
   input  logic [3:0] v,
   input  logic [1:0] dir,
   output logic [7:0] addr
);

   // Sprite is stored facing up; 15-x is taken as ~x (modulo 16).
   always_comb begin
      addr = {v, u};
      case (dir_t'(dir))
         DIR_UP:    addr = {v, u};
         DIR_RIGHT: addr = {~u, v};
         DIR_DOWN:  addr = {~v, ~u};
         DIR_LEFT:  addr = {u, ~v};
         default:   addr = {v, u};
      endcase
   end

endmodule

// File: rtl/snake_tail_sprite_pipe.sv
// rtl/snake_tail_sprite_pipe.sv - two-stage tail sprite pixel pipe around an external sprite ROM
module snake_tail_sprite_pipe
   import snake_gfx_pkg::*;
#(
   parameter int   GRID_W = 40,
   parameter int   GRID_H = 30,
   parameter rgb_t KEY0   = KEY0_DEFAULT,
   parameter rgb_t KEY1   = KEY1_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [9:0]  i_px_x,
   input  logic [9:0]  i_px_y,
   input  logic        i_de,
   input  logic        i_hsync,
   input  logic        i_vsync,
   input  logic [23:0] i_bg_rgb,
   input  logic [5:0]  i_tail_cell_x,
   input  logic [4:0]  i_tail_cell_y,
   input  logic [1:0]  i_tail_dir,
   input  logic        i_tail_valid,
   output logic        o_tail_ready,
   output logic [7:0]  o_rom_addr,
   input  logic [23:0] i_rom_data,
   output logic [23:0] o_rgb,
   output logic        o_de,
   output logic        o_hsync,
   output logic        o_vsync
);

   logic [5:0] pend_x, act_x;
   logic [4:0] pend_y, act_y;
   dir_t       pend_dir, act_dir;
   logic       pend_valid, act_valid;

   logic       hit_d1, de_d1, hs_d1, vs_d1;
   rgb_t       bg_d1;

   logic       accept, commit, in_grid, hit;
   logic [7:0] rot_addr;
   rgb_t       rgb_next;

   assign o_tail_ready = ~pend_valid;
   assign accept       = i_tail_valid & ~pend_valid;
   // o_vsync is the second vsync delay, so this is the frame-boundary edge.
   assign commit       = vs_d1 & ~o_vsync & pend_valid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pend_x     <= '0;
         pend_y     <= '0;
         pend_dir   <= DIR_UP;
         pend_valid <= 1'b0;
         act_x      <= '0;
         act_y      <= '0;
         act_dir    <= DIR_UP;
         act_valid  <= 1'b0;
      end else if (commit) begin
         act_x      <= pend_x;
         act_y      <= pend_y;
         act_dir    <= pend_dir;
         act_valid  <= 1'b1;
         pend_valid <= 1'b0;
      end else if (accept) begin
         pend_x     <= i_tail_cell_x;
         pend_y     <= i_tail_cell_y;
         pend_dir   <= dir_t'(i_tail_dir);
         pend_valid <= 1'b1;
      end
   end

   assign in_grid = (int'(act_x) < GRID_W) && (int'(act_y) < GRID_H);
   assign hit     = i_de & act_valid & in_grid
                  & (i_px_x[9:CELL_LOG2] == act_x)
                  & (i_px_y[9:CELL_LOG2] == {1'b0, act_y});

   tail_addr_rotate u_rot (
      .u    (i_px_x[CELL_LOG2-1:0]),
      .v    (i_px_y[CELL_LOG2-1:0]),
      .dir  (act_dir),
      .addr (rot_addr)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rom_addr <= '0;
         hit_d1     <= 1'b0;
         de_d1      <= 1'b0;
         hs_d1      <= 1'b0;
         vs_d1      <= 1'b0;
         bg_d1      <= '0;
      end else begin
         o_rom_addr <= rot_addr;
         hit_d1     <= hit;
         de_d1      <= i_de;
         hs_d1      <= i_hsync;
         vs_d1      <= i_vsync;
         bg_d1      <= i_bg_rgb;
      end
   end

   always_comb begin
      rgb_next = '0;
      if (!de_d1)
         rgb_next = '0;
      else if (hit_d1 && (i_rom_data != KEY0) && (i_rom_data != KEY1))
         rgb_next = i_rom_data;
      else
         rgb_next = bg_d1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rgb   <= '0;
         o_de    <= 1'b0;
         o_hsync <= 1'b0;
         o_vsync <= 1'b0;
      end else begin
         o_rgb   <= rgb_next;
         o_de    <= de_d1;
         o_hsync <= hs_d1;
         o_vsync <= vs_d1;
      end
   end

endmodule
